// File: rtl/debug_frame_tx.sv
// Debug snapshot transmitter: latches pipeline debug signals plus cycle count, streams them as a byte frame.
// Optional trailing XOR checksum byte enabled by defining DEBUG_FRAME_CSUM_EN.
module debug_frame_tx #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snap_req,
  input  logic [31:0] pc_incrementado,
  input  logic [31:0] instruction,
  input  logic [31:0] alu_result,
  input  logic [31:0] mux_wb_data,
  input  logic [4:0]  reg_dest_addr,
  input  logic [8:0]  ctrl,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        snap_drop,
  output logic [31:0] cycle_count
);

  // state   | meaning
  // IDLE    | waiting for snap_req, tx_valid low
  // HDR     | presenting HEADER byte
  // PAYLOAD | presenting captured byte idx (0..23), MSB of each word first
  // CSUM    | presenting XOR of the 24 payload bytes (checksum build only)
`ifdef DEBUG_FRAME_CSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
`endif

  state_t            state, state_nxt;
  logic [4:0]        idx;
  logic [5:0][31:0]  words;
  logic [31:0]       cur_word;
  logic [7:0]        pay_byte;
  logic              accept;
  logic              frame_end;
`ifdef DEBUG_FRAME_CSUM_EN
  logic [7:0]        csum;
`endif

  always_comb begin
    cur_word = '0;
    case (idx[4:2])
      3'd0:    cur_word = words[0];
      3'd1:    cur_word = words[1];
      3'd2:    cur_word = words[2];
      3'd3:    cur_word = words[3];
      3'd4:    cur_word = words[4];
      3'd5:    cur_word = words[5];
      default: cur_word = '0;
    endcase
    case (idx[1:0])
      2'd0:    pay_byte = cur_word[31:24];
      2'd1:    pay_byte = cur_word[23:16];
      2'd2:    pay_byte = cur_word[15:8];
      default: pay_byte = cur_word[7:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE: begin
        if (snap_req) state_nxt = HDR;
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = pay_byte;
`ifdef DEBUG_FRAME_CSUM_EN
        if (tx_ready && idx == 5'd23) state_nxt = CSUM;
`else
        if (tx_ready && idx == 5'd23) state_nxt = IDLE;
`endif
      end
`ifdef DEBUG_FRAME_CSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = tx_valid && tx_ready;
  assign frame_end = accept && (state_nxt == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      words       <= '0;
      cycle_count <= '0;
      frame_done  <= 1'b0;
      snap_drop   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cycle_count <= cycle_count + 32'd1;
      frame_done  <= frame_end;
      snap_drop   <= snap_req && (state != IDLE);
      if (state == IDLE) idx <= '0;
      else if (state == PAYLOAD && accept) idx <= idx + 5'd1;
      // Inputs are sampled only here, so a frame is immune to pipeline activity
      if (state == IDLE && snap_req) begin
        words[0] <= cycle_count;
        words[1] <= pc_incrementado;
        words[2] <= instruction;
        words[3] <= alu_result;
        words[4] <= mux_wb_data;
        words[5] <= {reg_dest_addr, 18'b0, ctrl};
      end
    end
  end

`ifdef DEBUG_FRAME_CSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      csum <= '0;
    else if (state == IDLE)          csum <= '0;
    else if (state == PAYLOAD && accept) csum <= csum ^ pay_byte;
  end
`endif

endmodule

// File: tb/tb_debug_frame_tx.sv
// Scoreboard bench for debug_frame_tx: a frame-level model pushes expected bytes, a negedge monitor checks.
module tb_debug_frame_tx;
  localparam logic [7:0] HDRB = 8'hA5;
`ifdef DEBUG_FRAME_CSUM_EN
  localparam int FLEN = 26;
`else
  localparam int FLEN = 25;
`endif

  logic        clk, reset, snap_req, tx_ready;
  logic [31:0] pc_incrementado, instruction, alu_result, mux_wb_data;
  logic [4:0]  reg_dest_addr;
  logic [8:0]  ctrl;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, frame_done, snap_drop;
  logic [31:0] cycle_count;

  debug_frame_tx #(.HEADER(HDRB)) dut (
    .clk(clk), .reset(reset), .snap_req(snap_req),
    .pc_incrementado(pc_incrementado), .instruction(instruction),
    .alu_result(alu_result), .mux_wb_data(mux_wb_data),
    .reg_dest_addr(reg_dest_addr), .ctrl(ctrl), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
    .frame_done(frame_done), .snap_drop(snap_drop), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: frame-level bookkeeping of bytes still owed downstream
  logic [31:0] m_count;
  int          left;
  int          m_before;
  logic [7:0]  exp_q[$];
  logic        exp_done, exp_drop;

  function automatic void push_frame();
    logic [31:0] w [6];
    logic [7:0]  b;
    logic [7:0]  cs;
    w[0] = m_count;
    w[1] = pc_incrementado;
    w[2] = instruction;
    w[3] = alu_result;
    w[4] = mux_wb_data;
    w[5] = {reg_dest_addr, 18'b0, ctrl};
    cs = 8'h00;
    exp_q.push_back(HDRB);
    for (int k = 0; k < 24; k++) begin
      b  = 8'(w[k / 4] >> (8 * (3 - (k % 4))));
      cs = cs ^ b;
      exp_q.push_back(b);
    end
`ifdef DEBUG_FRAME_CSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count  = '0;
      left     = 0;
      exp_q.delete();
      exp_done = 1'b0;
      exp_drop = 1'b0;
    end else begin
      m_before = left;
      exp_drop = snap_req && (m_before != 0);
      exp_done = 1'b0;
      if (m_before != 0 && tx_ready) begin
        left = left - 1;
        if (left == 0) exp_done = 1'b1;
      end
      if (snap_req && m_before == 0) begin
        push_frame();
        left = FLEN;
      end
      m_count = m_count + 32'd1;
    end
  end

  logic       stalled_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      chk("tx_valid", tx_valid, left != 0);
      chk("busy", busy, left != 0);
      chk("frame_done", frame_done, exp_done);
      chk("snap_drop", snap_drop, exp_drop);
      chk("cycle_count", cycle_count, m_count);
      if (stalled_prev) chk("stall_hold", tx_data, prev_data);
      if (tx_valid) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(tx_valid), 32'd0);
        else begin
          chk("tx_data", tx_data, exp_q[0]);
          if (tx_ready) void'(exp_q.pop_front());
        end
      end
      stalled_prev = tx_valid && !tx_ready;
      prev_data    = tx_data;
    end else begin
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_snap_drop", snap_drop, 1'b0);
      chk("rst_cycle_count", cycle_count, 32'd0);
      stalled_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] alu,
                          input logic [31:0] wb, input logic [4:0] rd, input logic [8:0] c);
    pc_incrementado = pc; instruction = ins; alu_result = alu;
    mux_wb_data = wb; reg_dest_addr = rd; ctrl = c;
  endtask

  task automatic set_directed();
    set_data(32'h0000_0004, 32'h8C01_0000, 32'h10, 32'h2A, 5'd1, 9'b110100011);
  endtask

  task automatic set_random();
    set_data($urandom, $urandom, $urandom, $urandom, 5'($urandom), 9'($urandom));
  endtask

  // Capture at the edge where the pre-increment cycle_count equals n
  task automatic snap_at(input logic [31:0] n);
    int i = 0;
    while (m_count != n && i < 300) begin tick(); i++; end
    chk("snap_at_timeout", m_count, n);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic snap_now();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (left != 0 && i < 400) begin tick(); i++; end
    chk("idle_timeout", left, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; snap_req = 1'b0; tx_ready = 1'b1;
    set_data('0, '0, '0, '0, '0, '0);
    tick(); tick(); tick();
    reset = 1'b1;

    // directed frame captured at cycle_count 5
    set_directed();
    snap_at(32'd5);
    wait_idle();
    tick(); tick();

    // all-zero data, cycle_count 5
    pulse_reset();
    set_data('0, '0, '0, '0, '0, '0);
    snap_at(32'd5);
    wait_idle();
    tick();

    // backpressure: tx_ready alternates 1,0,1,0
    set_directed();
    snap_now();
    for (int i = 0; i < 3 * FLEN && left != 0; i++) begin
      tx_ready = (i % 2 == 0);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle();
    tick();

    // requests during busy: at payload byte 3 and at the final accept edge
    set_random();
    snap_now();
    for (int i = 1; i <= FLEN + 3; i++) begin
      snap_req = (i == 5) || (i == FLEN);
      tick();
    end
    snap_req = 1'b0;
    tick(); tick();

    // reset asserted while payload byte 10 is on the bus
    set_random();
    snap_now();
    for (int i = 0; i < 11; i++) tick();
    reset = 1'b0;
    #1;
    chk("abort_tx_valid", tx_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    set_random();
    snap_now();
    wait_idle();
    tick();

    // randomized traffic, data changing under frames
    for (int i = 0; i < 1500; i++) begin
      tx_ready = ($urandom % 4) != 0;
      snap_req = ($urandom % 8) == 0;
      if (($urandom % 4) == 0) set_random();
      tick();
    end
    snap_req = 1'b0;
    tx_ready = 1'b1;
    wait_idle();
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
